mil_word_encoder: RTL and testbench
===================================

Name: mil_word_encoder

Overview:
- Single-clock MIL-STD-1553 word transmitter: accepts typed 16-bit words over a push handshake and emits Manchester-II biphase on a differential pair (tx_out/ntx_out).
- Adds sync pattern and odd parity.
- One-word holding buffer lets back-to-back words go out contiguously with zero gap.
- Sits between the SPI-side packet logic and the bus transceiver; its output feeds the existing receiver in loopback benches.

Parameters:
- HALFBIT_CYCLES, 25, clk cycles per half-bit (500 ns at 50 MHz clk); legal range ≥2.

Ports:
- clk  in  1  system clock
- nRst  in  1  asynchronous active-low reset
- push_request  in  1  word valid; held with push_type/push_word until push_done
- push_type  in  2  milStd1553 word type (WSERV, WDATA)
- push_word  in  16  word payload
- push_done  out  1  one-cycle pulse: word captured
- grant  in  1  transmit enable; low blocks starting a new word
- busy  out  1  high while holding buffer full or a word is on the line
- type_error  out  1  one-cycle pulse: captured word had an illegal type, dropped
- tx_out  out  1  positive bus line
- ntx_out  out  1  negative bus line

Behaviour:
- Reset (async): tx_out=0, ntx_out=0, push_done=0, busy=0, type_error=0; buffer empty; FSM IDLE; all timers 0. Reset mid-word stops the lines immediately; no partial completion.
- Line encoding: idle is tx_out=ntx_out=0. Active half-bits drive ntx_out=~tx_out.
  - Data 1 = high then low; data 0 = low then high.
  - WSERV sync = 3 half-bits high then 3 low; WDATA sync = 3 low then 3 high.
  - Parity bit = ~^push_word (odd over 16 data + parity), sent after bit 0. Data goes MSB first.
- Word = 40 half-bits = 40*HALFBIT_CYCLES clk.
- Handshake:
  - Capture when push_request=1, buffer empty, push_done=0; push_done pulses the next cycle.
  - No capture in the push_done cycle, so a still-high request is not double-accepted.
  - Illegal type: push_done and type_error pulse together; buffer stays empty.
- FSM:
  - IDLE→SYNC when buffer full & grant. Load the shifter ({word, parity}, 17 bits) and type, and empty the buffer, in that cycle. First active half-bit starts the next cycle. Latency push_request→first driven half-bit = 3 clk when idle and granted.
  - SYNC: 6 half-bits, then DATA.
  - DATA: 34 half-bits.
  - At the last cycle of the final half-bit: if buffer full & grant, reload and go to SYNC with no idle cycle (contiguous); else go to IDLE with lines 0.
- Buffer refill: buffer may capture a new word while SYNC/DATA runs. Buffer empties on load, and a capture may occur the cycle after load.
- grant deassert mid-word: current word completes; no new word starts until grant=1.
- busy = (state≠IDLE) | buffer full.
- Half-bit timer: counts 0..HALFBIT_CYCLES-1 and wraps. Half-bit index counter is 6 bits.

Decomposition:
- Package milStd1553 holds:
  - the word type enum (WSERV, WDATA; other encodings illegal);
  - a struct {type, word};
  - constants SYNC_HALFBITS=6, DATA_HALFBITS=34.
- Sub-module mil_halfbit_timer(clk, nRst, run, HALFBIT_CYCLES) outputs a strobe at the end of each half-bit. It restarts when run rises.

Test Plan:
1. Reset idle: nRst low 2 clk → tx_out=ntx_out=0, busy=0. Release → still 0 with no push.
2. WSERV 16'hEFAB, grant=1:
   - push_done 1 clk after request.
   - Line: 75 clk high, 75 low, then biphase 1110_1111_1010_1011, parity 1.
   - Total 1000 clk. The loopback receiver reports WSERV/EFAB.
3. Back-to-back WSERV EFAB then WDATA 16'h02A1:
   - Second push_done occurs during the first word.
   - WDATA sync (75 low, 75 high) begins the clk after the first parity half-bit ends, with no idle gap.
   - Parity 1. Receiver reports both words in order.
4. grant=0 at push of WDATA 16'h0001:
   - push_done pulses, busy=1, lines stay 0.
   - grant=1 at t0 → sync starts at t0+2 clk. Parity bit 0.
5. Illegal type (2'b11) with word 16'h1234 → push_done and type_error pulse same cycle, lines stay idle, busy=0.
6. nRst asserted at half-bit 20 of a word → tx_out/ntx_out=0 asynchronously. After release, a new WDATA 16'hFFFF transmits correctly with parity 1.

Source files
------------

// File: rtl/mil_word_encoder_pkg.sv
// MIL-STD-1553 shared types for the word transmitter.
// Word types, buffered word bundle and frame lengths.
package milStd1553;

  typedef enum logic [1:0] {
    WSERV = 2'b01,
    WDATA = 2'b10
  } word_type_e;

  typedef struct packed {
    word_type_e  wtype;
    logic [15:0] word;
  } mil_word_t;

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    DATA
  } tx_state_e;

  localparam int SYNC_HALFBITS = 6;
  localparam int DATA_HALFBITS = 34;

  function automatic logic type_legal(input logic [1:0] t);
    return (t == WSERV) || (t == WDATA);
  endfunction

endpackage

// File: rtl/mil_word_encoder_timer.sv
// Half-bit timer: strobes on the last clk of every half-bit.
// Held at zero while idle so each word starts on a fresh half-bit.
module mil_halfbit_timer #(
  parameter int HALFBIT_CYCLES = 25
) (
  input  logic clk,
  input  logic nRst,
  input  logic run,
  output logic strobe
);

  localparam int W = $clog2(HALFBIT_CYCLES);
  localparam logic [W-1:0] LAST = W'(HALFBIT_CYCLES - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      cnt <= '0;
    end else if (!run || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

  assign strobe = run && (cnt == LAST);

endmodule

// File: rtl/mil_word_encoder.sv
// MIL-STD-1553 word transmitter: sync, Manchester-II data, odd parity.
// One-word holding buffer allows back-to-back words with no gap.
module mil_word_encoder
  import milStd1553::*;
#(
  parameter int HALFBIT_CYCLES = 25
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic        push_request,
  input  logic [1:0]  push_type,
  input  logic [15:0] push_word,
  output logic        push_done,
  input  logic        grant,
  output logic        busy,
  output logic        type_error,
  output logic        tx_out,
  output logic        ntx_out
);

  tx_state_e  state;
  mil_word_t  buf_q;
  logic       buf_full;
  logic [16:0] shreg;
  word_type_e cur_type;
  logic [5:0] hb_idx;
  logic       run;
  logic       strobe;
  logic       word_end;
  logic       load;
  logic       capture;
  logic       legal;
  logic       line;

  assign run      = (state != IDLE);
  assign word_end = strobe && (state == DATA)
                 && (hb_idx == 6'(DATA_HALFBITS - 1));
  assign load     = buf_full && grant
                 && ((state == IDLE) || word_end);
  assign capture  = push_request && !buf_full && !push_done;
  assign legal    = type_legal(push_type);
  assign busy     = run || buf_full;

  mil_halfbit_timer #(
    .HALFBIT_CYCLES(HALFBIT_CYCLES)
  ) u_timer (
    .clk   (clk),
    .nRst  (nRst),
    .run   (run),
    .strobe(strobe)
  );

  // Line level of the half-bit in progress; registered below.
  always_comb begin
    line = 1'b0;
    unique case (1'b1)
      state == SYNC:
        line = (hb_idx < 6'(SYNC_HALFBITS / 2))
             ^ (cur_type == WDATA);
      state == DATA:
        line = shreg[16] ^ hb_idx[0];
      default:
        line = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state      <= IDLE;
      buf_q      <= '0;
      buf_full   <= 1'b0;
      shreg      <= '0;
      cur_type   <= WSERV;
      hb_idx     <= '0;
      push_done  <= 1'b0;
      type_error <= 1'b0;
      tx_out     <= 1'b0;
      ntx_out    <= 1'b0;
    end else begin
      push_done  <= capture;
      type_error <= capture && !legal;
      tx_out     <= line;
      ntx_out    <= run && !line;

      if (capture && legal) begin
        buf_full    <= 1'b1;
        buf_q.wtype <= word_type_e'(push_type);
        buf_q.word  <= push_word;
      end else if (load) begin
        buf_full <= 1'b0;
      end

      if (load) begin
        state    <= SYNC;
        hb_idx   <= '0;
        shreg    <= {buf_q.word, ~^buf_q.word};
        cur_type <= buf_q.wtype;
      end else begin
        unique case (state)
          SYNC: if (strobe) begin
            if (hb_idx == 6'(SYNC_HALFBITS - 1)) begin
              state  <= DATA;
              hb_idx <= '0;
            end else begin
              hb_idx <= hb_idx + 6'd1;
            end
          end
          DATA: if (strobe) begin
            if (word_end) begin
              state  <= IDLE;
              hb_idx <= '0;
            end else begin
              hb_idx <= hb_idx + 6'd1;
              if (hb_idx[0]) shreg <= {shreg[15:0], 1'b0};
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mil_word_encoder.sv
// Bench for mil_word_encoder: directed scenarios plus random words.
// Line checked per clk against a half-bit table built from the word.
module tb_mil_word_encoder;
  import milStd1553::*;

  localparam int HB       = 25;
  localparam int WORD_CYC = 40 * HB;

  logic        clk = 1'b0;
  logic        nRst = 1'b0;
  logic        push_request = 1'b0;
  logic [1:0]  push_type = 2'b00;
  logic [15:0] push_word = 16'h0;
  logic        grant = 1'b0;
  logic        push_done, busy, type_error, tx_out, ntx_out;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int words_done = 0;
  logic [17:0] exp_q[$];
  int starts[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mil_word_encoder #(.HALFBIT_CYCLES(HB)) dut (
    .clk         (clk),
    .nRst        (nRst),
    .push_request(push_request),
    .push_type   (push_type),
    .push_word   (push_word),
    .push_done   (push_done),
    .grant       (grant),
    .busy        (busy),
    .type_error  (type_error),
    .tx_out      (tx_out),
    .ntx_out     (ntx_out)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Expected level of half-bit k (0..39) of a {type, word} frame.
  function automatic logic exp_half(input logic [17:0] e, input int k);
    logic [1:0]  t;
    logic [15:0] w;
    logic        b;
    int          bi;
    t = e[17:16];
    w = e[15:0];
    if (k < 6) return (t == WSERV) ? (k < 3) : (k >= 3);
    bi = (k - 6) / 2;
    b  = (bi < 16) ? w[15 - bi] : ~^w;
    return ((k - 6) % 2 == 0) ? b : !b;
  endfunction

  // Line monitor: one check per transmitted word.
  logic [17:0] m_e;
  int          m_bad;
  bit          m_abort;
  logic        m_b;
  initial begin
    forever begin
      @(negedge clk);
      if (nRst && (tx_out || ntx_out)) begin
        starts.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk("unexpected_word", {31'd0, tx_out}, {31'd0, ~tx_out});
          for (int k = 0; k < 2 * WORD_CYC && (tx_out || ntx_out); k++)
            @(negedge clk);
          continue;
        end
        m_e = exp_q.pop_front();
        m_bad = 0;
        m_abort = 0;
        for (int j = 0; j < WORD_CYC; j++) begin
          if (j > 0) @(negedge clk);
          if (!nRst) begin
            m_abort = 1;
            break;
          end
          m_b = exp_half(m_e, j / HB);
          if (tx_out !== m_b || ntx_out !== !m_b) m_bad++;
        end
        if (!m_abort) begin
          chk($sformatf("word_%0h_%0h", m_e[17:16], m_e[15:0]),
              m_bad, 0);
          words_done++;
        end
      end
    end
  end

  task automatic push(input logic [1:0] t, input logic [15:0] w,
                      output bit te, output int rq, output int dn);
    @(posedge clk);
    #1;
    push_request = 1'b1;
    push_type = t;
    push_word = w;
    rq = cyc;
    dn = -1;
    te = 0;
    for (int i = 0; i < 3 * WORD_CYC; i++) begin
      @(negedge clk);
      if (push_done) begin
        dn = cyc;
        te = type_error;
        break;
      end
    end
    if (dn < 0) chk("push_done_seen", {31'd0, push_done}, 32'd1);
    else if (type_legal(t)) exp_q.push_back({t, w});
    @(posedge clk);
    #1;
    push_request = 1'b0;
  endtask

  task automatic wait_words(input int n, input int limit);
    for (int i = 0; i < limit && words_done < n; i++) @(negedge clk);
    chk("words_done", words_done, n);
  endtask

  bit         te;
  int         rq, dn, rq2, dn2, t0, sidx, nw, act, n_exp;
  logic [1:0] rt;
  logic [15:0] rw;

  initial begin
    // 1: reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tx", {31'd0, tx_out}, 0);
    chk("rst_ntx", {31'd0, ntx_out}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, push_done}, 0);
    nRst = 1'b1;
    grant = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_tx", {31'd0, tx_out | ntx_out}, 0);
    chk("idle_busy", {31'd0, busy}, 0);

    // 2: single WSERV
    push(WSERV, 16'hEFAB, te, rq, dn);
    chk("t2_done_lat", dn - rq, 1);
    chk("t2_te", {31'd0, te}, 0);
    wait_words(1, 2 * WORD_CYC);
    chk("t2_latency", starts[0] - rq, 3);
    @(negedge clk);
    chk("t2_end_idle", {31'd0, tx_out | ntx_out}, 0);
    chk("t2_end_busy", {31'd0, busy}, 0);

    // 3: back-to-back, contiguous
    nw = words_done;
    sidx = starts.size();
    push(WSERV, 16'hEFAB, te, rq, dn);
    push(WDATA, 16'h02A1, te, rq2, dn2);
    chk("t3_te", {31'd0, te}, 0);
    wait_words(nw + 2, 3 * WORD_CYC);
    chk("t3_contig", starts[sidx + 1] - starts[sidx], WORD_CYC);
    chk("t3_done_early",
        {31'd0, dn2 < starts[sidx] + WORD_CYC}, 1);

    // 4: grant held off
    repeat (3) @(negedge clk);
    grant = 1'b0;
    nw = words_done;
    push(WDATA, 16'h0001, te, rq, dn);
    act = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx_out || ntx_out) act++;
    end
    chk("t4_busy", {31'd0, busy}, 1);
    chk("t4_lines_idle", act, 0);
    sidx = starts.size();
    @(posedge clk);
    #1;
    grant = 1'b1;
    t0 = cyc;
    wait_words(nw + 1, 2 * WORD_CYC);
    chk("t4_grant_lat", starts[sidx] - t0, 2);

    // 5: illegal type
    repeat (3) @(negedge clk);
    push(2'b11, 16'h1234, te, rq, dn);
    chk("t5_type_error", {31'd0, te}, 1);
    chk("t5_done_lat", dn - rq, 1);
    act = 0;
    repeat (10) begin
      @(negedge clk);
      if (tx_out || ntx_out || busy) act++;
    end
    chk("t5_stay_idle", act, 0);

    // 6: reset mid-word, then recover
    nw = words_done;
    sidx = starts.size();
    push(WDATA, 16'h5A5A, te, rq, dn);
    for (int i = 0; i < 10 && starts.size() <= sidx; i++)
      @(negedge clk);
    repeat (20 * HB) @(posedge clk);
    #3;
    nRst = 1'b0;
    #1;
    chk("t6_rst_tx", {31'd0, tx_out}, 0);
    chk("t6_rst_ntx", {31'd0, ntx_out}, 0);
    chk("t6_rst_busy", {31'd0, busy}, 0);
    repeat (2) @(posedge clk);
    #1;
    nRst = 1'b1;
    exp_q.delete();
    push(WDATA, 16'hFFFF, te, rq, dn);
    wait_words(nw + 1, 2 * WORD_CYC);

    // random words with random gaps
    nw = words_done;
    n_exp = 0;
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(4) == 0) rt = 2'b11;
      else rt = $urandom_range(1) ? WSERV : WDATA;
      rw = 16'($urandom);
      push(rt, rw, te, rq, dn);
      chk($sformatf("rnd_te_%0d", i), {31'd0, te},
          {31'd0, rt == 2'b11});
      if (rt != 2'b11) n_exp++;
      repeat ($urandom_range(2)) @(posedge clk);
    end
    wait_words(nw + n_exp, 16 * WORD_CYC);
    repeat (2) @(negedge clk);
    chk("rnd_end_busy", {31'd0, busy}, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
